// File: rtl/usb_line_pkg.sv
// Shared line-state encoding and decode helper for the USB line monitor.
package usb_line_pkg;

    // Encoding matches the raw {D+, D-} pair, so decoding is just a cast.
    typedef enum logic [1:0] {
        J   = 2'b10,
        K   = 2'b01,
        SE0 = 2'b00,
        SE1 = 2'b11
    } line_state_t;

    function automatic line_state_t decode_line(input logic dp, input logic dm);
        return line_state_t'({dp, dm});
    endfunction

endpackage

// File: rtl/usb_sync_filter.sv
// Synchronises raw D+/D- into clk and accepts a new line state only after it
// has been stable for FILTER_LEN consecutive samples.
module usb_sync_filter
    import usb_line_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_dp,
    input  logic        i_dm,
    output line_state_t o_filt,  // accepted line state
    output logic        o_upd,   // o_filt takes a new value at the coming edge
    output logic        o_chg,   // one cycle after o_filt changed
    output line_state_t o_old    // state o_filt held before that change
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] r_dp_sync;
    logic [SYNC_STAGES-1:0] r_dm_sync;
    line_state_t            r_filt;
    line_state_t            r_cand;
    line_state_t            r_old;
    logic [CW-1:0]          r_cnt;
    logic                   r_chg;

    line_state_t            w_sync;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_upd;

    // Plain shift-register synchronisers; reset to the J pattern so an idle
    // bus produces no activity when reset is released.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dp_sync <= '1;
            r_dm_sync <= '0;
        end else begin
            r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], i_dp};
            r_dm_sync <= {r_dm_sync[SYNC_STAGES-2:0], i_dm};
        end
    end

    // Run length of the current synced value including this sample; a new
    // value (r_cand holds the previous sample) restarts the run at 1.
    always_comb begin
        w_sync     = decode_line(r_dp_sync[SYNC_STAGES-1], r_dm_sync[SYNC_STAGES-1]);
        w_cnt_next = (w_sync == r_cand) ? r_cnt + CW'(1) : CW'(1);
        w_upd      = (w_sync != r_filt) && (w_cnt_next >= CW'(FILTER_LEN));
    end

    // Filter state: the count only tracks values that differ from r_filt, so
    // a return to the accepted state wipes any partial run.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_filt <= J;
            r_cand <= J;
            r_cnt  <= '0;
            r_chg  <= 1'b0;
            r_old  <= J;
        end else begin
            r_cand <= w_sync;
            r_chg  <= w_upd;
            if (w_upd) begin
                r_old  <= r_filt;
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else if (w_sync == r_filt) begin
                r_cnt  <= '0;
            end else begin
                r_cnt  <= w_cnt_next;
            end
        end
    end

    assign o_filt = r_filt;
    assign o_upd  = w_upd;
    assign o_chg  = r_chg;
    assign o_old  = r_old;

endmodule

// File: rtl/usb_line_monitor.sv
// USB D+/D- line monitor: filtered line state, differential edge, EOP,
// line-error, bus-reset and idle indications for the RX decoder.
module usb_line_monitor
    import usb_line_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 2,
    parameter int EDGE_MODE    = 0,
    parameter int EOP_MIN_CLKS = 12,
    parameter int RESET_CLKS   = 80,
    parameter int IDLE_CLKS    = 56
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        d_plus,
    input  logic        d_minus,
    output line_state_t line_state,
    output logic        d_edge,
    output logic        eop,
    output logic        line_err,
    output logic        bus_reset,
    output logic        idle
);

    localparam int RUN_MAX = (RESET_CLKS > IDLE_CLKS) ? RESET_CLKS : IDLE_CLKS;
    localparam int RW      = $clog2(RUN_MAX + 1);

    line_state_t   w_filt;
    line_state_t   w_old;
    logic          w_upd;
    logic          w_chg;
    logic          w_jk;
    logic          w_from_se0;
    logic          w_edge_ev;
    logic          w_eop_ev;
    logic          w_err_ev;

    logic [RW-1:0] r_run;
    logic [RW-1:0] r_run_pre;
    logic          r_d_edge;
    logic          r_eop;
    logic          r_line_err;

    usb_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync_filter (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_dp   (d_plus),
        .i_dm   (d_minus),
        .o_filt (w_filt),
        .o_upd  (w_upd),
        .o_chg  (w_chg),
        .o_old  (w_old)
    );

    // Run length of the filtered state; the pre-change length is kept so the
    // EOP decision one cycle later still sees how long SE0 lasted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_run     <= '0;
            r_run_pre <= '0;
        end else if (w_upd) begin
            r_run     <= RW'(1);
            r_run_pre <= r_run;
        end else if (r_run != RW'(RUN_MAX)) begin
            r_run     <= r_run + RW'(1);
        end
    end

    // Classify the transition reported by the filter (old -> current state).
    always_comb begin
        w_jk       = ((w_old == J) && (w_filt == K)) || ((w_old == K) && (w_filt == J));
        w_from_se0 = (w_old == SE0);
        w_edge_ev  = w_chg && ((EDGE_MODE != 0) || w_jk);
        w_eop_ev   = w_chg && w_from_se0 && (w_filt == J) && (r_run_pre >= RW'(EOP_MIN_CLKS));
        w_err_ev   = w_chg && w_from_se0 && ((w_filt == K) || (w_filt == SE1));
    end

    // Registered single-cycle event pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_d_edge   <= 1'b0;
            r_eop      <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_d_edge   <= w_edge_ev;
            r_eop      <= w_eop_ev;
            r_line_err <= w_err_ev;
        end
    end

    assign line_state = w_filt;
    assign d_edge     = r_d_edge;
    assign eop        = r_eop;
    assign line_err   = r_line_err;
    assign bus_reset  = (w_filt == SE0) && (r_run >= RW'(RESET_CLKS));
    assign idle       = (w_filt == J) && (r_run >= RW'(IDLE_CLKS));

endmodule
